// File: rtl/data_mem_controller.sv
// data_mem_controller
// Arbitrates LSU load/store requests from NUM_CONSUMERS ports onto
// NUM_CHANNELS memory channels. Each channel claims one pending consumer,
// performs the memory transaction and relays the result back with a
// four-phase valid/ready handshake.
//
// Optional feature: define DATA_MEM_CTRL_ROUND_ROBIN_EN to give every channel
// a rotating scan start pointer. Without it, the lowest consumer index wins.
module data_mem_controller #(
  parameter int NUM_CONSUMERS = 8,
  parameter int NUM_CHANNELS  = 4,
  parameter int ADDR_WIDTH    = 8,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  consumer_read_valid    [NUM_CONSUMERS],
  input  logic [ADDR_WIDTH-1:0] consumer_read_address  [NUM_CONSUMERS],
  output logic                  consumer_read_ready    [NUM_CONSUMERS],
  output logic [DATA_WIDTH-1:0] consumer_read_data     [NUM_CONSUMERS],
  input  logic                  consumer_write_valid   [NUM_CONSUMERS],
  input  logic [ADDR_WIDTH-1:0] consumer_write_address [NUM_CONSUMERS],
  input  logic [DATA_WIDTH-1:0] consumer_write_data    [NUM_CONSUMERS],
  output logic                  consumer_write_ready   [NUM_CONSUMERS],
  output logic                  mem_read_valid         [NUM_CHANNELS],
  output logic [ADDR_WIDTH-1:0] mem_read_address       [NUM_CHANNELS],
  input  logic                  mem_read_ready         [NUM_CHANNELS],
  input  logic [DATA_WIDTH-1:0] mem_read_data          [NUM_CHANNELS],
  output logic                  mem_write_valid        [NUM_CHANNELS],
  output logic [ADDR_WIDTH-1:0] mem_write_address      [NUM_CHANNELS],
  output logic [DATA_WIDTH-1:0] mem_write_data         [NUM_CHANNELS],
  input  logic                  mem_write_ready        [NUM_CHANNELS]
);

  localparam int IDX_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE          = 2'd0,
    ST_READ_WAITING  = 2'd1,
    ST_WRITE_WAITING = 2'd2,
    ST_RELAYING      = 2'd3
  } state_t;

  state_t                  state_r            [NUM_CHANNELS];
  logic [IDX_W-1:0]        current_consumer_r [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] is_read_r;
  logic [NUM_CONSUMERS-1:0] claimed_r;

  logic [NUM_CHANNELS-1:0] pick_valid_s;
  logic [IDX_W-1:0]        pick_idx_s [NUM_CHANNELS];

`ifdef DATA_MEM_CTRL_ROUND_ROBIN_EN
  logic [IDX_W-1:0] rr_ptr_r [NUM_CHANNELS];

  // Next scan start after granting idx: one past it, wrapping at NUM_CONSUMERS.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
    logic [IDX_W-1:0] nxt;
    if (int'(idx) == NUM_CONSUMERS - 1) begin
      nxt = '0;
    end else begin
      nxt = idx + IDX_W'(1);
    end
    return nxt;
  endfunction
`endif

  // Per-channel request scan; lower-index channels pick first so no consumer
  // is picked twice in one cycle, and claimed consumers are skipped.
  always_comb begin : scan_comb
    logic [NUM_CONSUMERS-1:0] taken_s;
    logic                     found_s;
    logic [IDX_W-1:0]         start_s;
    logic [IDX_W-1:0]         cand_s;
    int                       cand_int_s;
    taken_s    = '0;
    found_s    = 1'b0;
    start_s    = '0;
    cand_s     = '0;
    cand_int_s = 0;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      pick_valid_s[ch] = 1'b0;
      pick_idx_s[ch]   = '0;
    end
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      found_s = 1'b0;
`ifdef DATA_MEM_CTRL_ROUND_ROBIN_EN
      start_s = rr_ptr_r[ch];
`else
      start_s = '0;
`endif
      for (int k = 0; k < NUM_CONSUMERS; k++) begin
        cand_int_s = int'(start_s) + k;
        if (cand_int_s >= NUM_CONSUMERS) begin
          cand_int_s = cand_int_s - NUM_CONSUMERS;
        end else begin
          cand_int_s = cand_int_s;
        end
        cand_s = IDX_W'(cand_int_s);
        if ((state_r[ch] == ST_IDLE) && !found_s && !claimed_r[cand_s] &&
            !taken_s[cand_s] &&
            (consumer_read_valid[cand_s] || consumer_write_valid[cand_s])) begin
          found_s          = 1'b1;
          pick_valid_s[ch] = 1'b1;
          pick_idx_s[ch]   = cand_s;
          taken_s[cand_s]  = 1'b1;
        end else begin
          found_s = found_s;
        end
      end
    end
  end

  // Channel FSMs, claim bookkeeping and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      claimed_r <= '0;
      is_read_r <= '0;
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        state_r[ch]            <= ST_IDLE;
        current_consumer_r[ch] <= '0;
        mem_read_valid[ch]     <= 1'b0;
        mem_read_address[ch]   <= '0;
        mem_write_valid[ch]    <= 1'b0;
        mem_write_address[ch]  <= '0;
        mem_write_data[ch]     <= '0;
`ifdef DATA_MEM_CTRL_ROUND_ROBIN_EN
        rr_ptr_r[ch]           <= '0;
`endif
      end
      for (int c = 0; c < NUM_CONSUMERS; c++) begin
        consumer_read_ready[c]  <= 1'b0;
        consumer_read_data[c]   <= '0;
        consumer_write_ready[c] <= 1'b0;
      end
    end else begin
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        case (state_r[ch])
          ST_IDLE: begin
            if (pick_valid_s[ch]) begin
              claimed_r[pick_idx_s[ch]] <= 1'b1;
              current_consumer_r[ch]    <= pick_idx_s[ch];
`ifdef DATA_MEM_CTRL_ROUND_ROBIN_EN
              rr_ptr_r[ch]              <= wrap_inc(pick_idx_s[ch]);
`endif
              // A consumer raising both valids is served as a read.
              if (consumer_read_valid[pick_idx_s[ch]]) begin
                is_read_r[ch]        <= 1'b1;
                mem_read_valid[ch]   <= 1'b1;
                mem_read_address[ch] <= consumer_read_address[pick_idx_s[ch]];
                state_r[ch]          <= ST_READ_WAITING;
              end else begin
                is_read_r[ch]         <= 1'b0;
                mem_write_valid[ch]   <= 1'b1;
                mem_write_address[ch] <= consumer_write_address[pick_idx_s[ch]];
                mem_write_data[ch]    <= consumer_write_data[pick_idx_s[ch]];
                state_r[ch]           <= ST_WRITE_WAITING;
              end
            end
          end
          ST_READ_WAITING: begin
            if (mem_read_ready[ch]) begin
              mem_read_valid[ch]                          <= 1'b0;
              consumer_read_ready[current_consumer_r[ch]] <= 1'b1;
              consumer_read_data[current_consumer_r[ch]]  <= mem_read_data[ch];
              state_r[ch]                                 <= ST_RELAYING;
            end
          end
          ST_WRITE_WAITING: begin
            if (mem_write_ready[ch]) begin
              mem_write_valid[ch]                          <= 1'b0;
              consumer_write_ready[current_consumer_r[ch]] <= 1'b1;
              state_r[ch]                                  <= ST_RELAYING;
            end
          end
          ST_RELAYING: begin
            // Hold ready until the owner drops the matching valid.
            if (is_read_r[ch] ? !consumer_read_valid[current_consumer_r[ch]]
                              : !consumer_write_valid[current_consumer_r[ch]]) begin
              consumer_read_ready[current_consumer_r[ch]]  <= 1'b0;
              consumer_write_ready[current_consumer_r[ch]] <= 1'b0;
              claimed_r[current_consumer_r[ch]]            <= 1'b0;
              state_r[ch]                                  <= ST_IDLE;
            end
          end
          default: begin
            state_r[ch] <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_data_mem_controller.sv
// Self-checking bench for data_mem_controller: table-driven single
// transactions plus hand-written oversubscription, fairness and reset cases.
module tb_data_mem_controller;

  localparam int NC  = 8;
  localparam int NCH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       consumer_read_valid    [NC];
  logic [7:0] consumer_read_address  [NC];
  logic       consumer_read_ready    [NC];
  logic [7:0] consumer_read_data     [NC];
  logic       consumer_write_valid   [NC];
  logic [7:0] consumer_write_address [NC];
  logic [7:0] consumer_write_data    [NC];
  logic       consumer_write_ready   [NC];
  logic       mem_read_valid         [NCH];
  logic [7:0] mem_read_address       [NCH];
  logic       mem_read_ready         [NCH];
  logic [7:0] mem_read_data          [NCH];
  logic       mem_write_valid        [NCH];
  logic [7:0] mem_write_address      [NCH];
  logic [7:0] mem_write_data         [NCH];
  logic       mem_write_ready        [NCH];

  data_mem_controller #(.NUM_CONSUMERS(NC), .NUM_CHANNELS(NCH), .ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .consumer_read_valid(consumer_read_valid), .consumer_read_address(consumer_read_address),
    .consumer_read_ready(consumer_read_ready), .consumer_read_data(consumer_read_data),
    .consumer_write_valid(consumer_write_valid), .consumer_write_address(consumer_write_address),
    .consumer_write_data(consumer_write_data), .consumer_write_ready(consumer_write_ready),
    .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
    .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready)
  );

  // Single-channel instance for the fairness sequence.
  logic       f_crv [NC];
  logic [7:0] f_cra [NC];
  logic       f_crr [NC];
  logic [7:0] f_crd [NC];
  logic       f_cwv [NC];
  logic [7:0] f_cwa [NC];
  logic [7:0] f_cwd [NC];
  logic       f_cwr [NC];
  logic       f_mrv [1];
  logic [7:0] f_mra [1];
  logic       f_mrr [1];
  logic [7:0] f_mrd [1];
  logic       f_mwv [1];
  logic [7:0] f_mwa [1];
  logic [7:0] f_mwd [1];
  logic       f_mwr [1];

  data_mem_controller #(.NUM_CONSUMERS(NC), .NUM_CHANNELS(1), .ADDR_WIDTH(8), .DATA_WIDTH(8)) dut_fair (
    .clk(clk), .reset(reset),
    .consumer_read_valid(f_crv), .consumer_read_address(f_cra),
    .consumer_read_ready(f_crr), .consumer_read_data(f_crd),
    .consumer_write_valid(f_cwv), .consumer_write_address(f_cwa),
    .consumer_write_data(f_cwd), .consumer_write_ready(f_cwr),
    .mem_read_valid(f_mrv), .mem_read_address(f_mra),
    .mem_read_ready(f_mrr), .mem_read_data(f_mrd),
    .mem_write_valid(f_mwv), .mem_write_address(f_mwa),
    .mem_write_data(f_mwd), .mem_write_ready(f_mwr)
  );

  typedef struct {
    bit         is_wr;
    int         cons;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         lat;
    logic [7:0] exp_rd;
  } vec_t;

  int tests_run = 0;
  int tests_failed = 0;

  int lat_g = 0;
  int cyc_g = 0;
  int rcnt [NCH];
  int wcnt [NCH];
  logic [7:0] wr_log_addr;
  logic [7:0] wr_log_data;
  int served [NC];
  int served_at [NC];
  logic [7:0] got [NC];

  bit f_en = 1'b0;
  bit f_prev = 1'b0;
  int f_ng = 0;
  logic [7:0] f_grant [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory contents seen by the channels: a fixed function of the address.
  function automatic logic [7:0] mem_f(input logic [7:0] a);
    return a + 8'h4A;
  endfunction

  // One clock: wait for the edge, then run memory, LSU and fairness models.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc_g++;
    for (int ch = 0; ch < NCH; ch++) begin
      if (mem_read_valid[ch] && !mem_read_ready[ch]) begin
        if (rcnt[ch] >= lat_g) begin
          mem_read_ready[ch] = 1'b1;
          mem_read_data[ch]  = mem_f(mem_read_address[ch]);
          rcnt[ch] = 0;
        end else begin
          rcnt[ch]++;
        end
      end else begin
        mem_read_ready[ch] = 1'b0;
        rcnt[ch] = 0;
      end
      if (mem_write_valid[ch] && !mem_write_ready[ch]) begin
        if (wcnt[ch] >= lat_g) begin
          mem_write_ready[ch] = 1'b1;
          wr_log_addr = mem_write_address[ch];
          wr_log_data = mem_write_data[ch];
          wcnt[ch] = 0;
        end else begin
          wcnt[ch]++;
        end
      end else begin
        mem_write_ready[ch] = 1'b0;
        wcnt[ch] = 0;
      end
    end
    for (int c = 0; c < NC; c++) begin
      if (consumer_read_valid[c] && consumer_read_ready[c]) begin
        got[c] = consumer_read_data[c];
        consumer_read_valid[c] = 1'b0;
        served[c]++;
        served_at[c] = cyc_g;
      end
      if (consumer_write_valid[c] && consumer_write_ready[c]) begin
        consumer_write_valid[c] = 1'b0;
        served[c]++;
        served_at[c] = cyc_g;
      end
    end
    if (f_mrv[0] && !f_prev) begin
      if (f_ng < 4) f_grant[f_ng] = f_mra[0];
      f_ng++;
    end
    f_prev = f_mrv[0];
    for (int c = 0; c < 2; c++) begin
      f_crv[c] = f_en ? !f_crr[c] : 1'b0;
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int cyc = 0;
    int hi = 0;
    int bad = 0;
    int other = 0;
    served[v.cons] = 0;
    lat_g = v.lat;
    if (v.is_wr) begin
      consumer_write_address[v.cons] = v.addr;
      consumer_write_data[v.cons]    = v.wdata;
      consumer_write_valid[v.cons]   = 1'b1;
    end else begin
      consumer_read_address[v.cons] = v.addr;
      consumer_read_valid[v.cons]   = 1'b1;
    end
    while (served[v.cons] == 0 && cyc < 50) begin
      tick();
      cyc++;
      for (int ch = 0; ch < NCH; ch++) begin
        if (v.is_wr ? mem_read_valid[ch] : mem_write_valid[ch]) other++;
      end
      if (v.is_wr ? mem_write_valid[0] : mem_read_valid[0]) begin
        hi++;
        if (v.is_wr ? (mem_write_address[0] !== v.addr || mem_write_data[0] !== v.wdata)
                    : (mem_read_address[0] !== v.addr)) bad++;
      end
    end
    check({tag, " latency"}, 32'(cyc), 32'(v.lat + 2));
    check({tag, " mem_valid_held"}, 32'(hi), 32'(v.lat + 1));
    check({tag, " payload_stable"}, 32'(bad), 32'd0);
    check({tag, " other_side_idle"}, 32'(other), 32'd0);
    if (v.is_wr) begin
      check({tag, " mem_write"}, 32'({wr_log_addr, wr_log_data}), 32'({v.addr, v.wdata}));
    end else begin
      check({tag, " read_data"}, 32'(got[v.cons]), 32'(v.exp_rd));
    end
    tick();
    check({tag, " ready_released"},
          32'({consumer_read_ready[v.cons], consumer_write_ready[v.cons]}), 32'd0);
  endtask

  vec_t vecs [6];
  logic [7:0] ov_addr [NC];
  logic [7:0] ov_data [NC];
  logic [7:0] fair_exp [4];

  initial begin
    int sum;
    int bad;
    int cyc;
    vec_t fresh;
    // {is_wr, consumer, address, write data, memory latency, expected read data}
    vecs[0] = '{1'b0, 2, 8'h10, 8'h00, 0, 8'h5A};
    vecs[1] = '{1'b1, 5, 8'h20, 8'h33, 0, 8'h00};
    vecs[2] = '{1'b0, 7, 8'hC0, 8'h00, 1, 8'h0A};
    vecs[3] = '{1'b1, 0, 8'hFF, 8'h81, 2, 8'h00};
    vecs[4] = '{1'b0, 0, 8'hB6, 8'h00, 5, 8'h00};
    vecs[5] = '{1'b0, 3, 8'h00, 8'h00, 0, 8'h4A};
    ov_addr = '{8'h40, 8'h43, 8'h46, 8'h49, 8'h4C, 8'h4F, 8'h52, 8'h55};
    ov_data = '{8'h8A, 8'h8D, 8'h90, 8'h93, 8'h96, 8'h99, 8'h9C, 8'h9F};
`ifdef DATA_MEM_CTRL_ROUND_ROBIN_EN
    fair_exp = '{8'h00, 8'h01, 8'h00, 8'h01};
`else
    fair_exp = '{8'h00, 8'h00, 8'h00, 8'h00};
`endif

    reset = 1'b1;
    for (int c = 0; c < NC; c++) begin
      consumer_read_valid[c] = 1'b0;  consumer_read_address[c] = 8'h00;
      consumer_write_valid[c] = 1'b0; consumer_write_address[c] = 8'h00;
      consumer_write_data[c] = 8'h00; served[c] = 0; served_at[c] = 0; got[c] = 8'h00;
      f_crv[c] = 1'b0; f_cra[c] = 8'(c); f_cwv[c] = 1'b0; f_cwa[c] = 8'h00; f_cwd[c] = 8'h00;
    end
    for (int ch = 0; ch < NCH; ch++) begin
      mem_read_ready[ch] = 1'b0; mem_read_data[ch] = 8'h00;
      mem_write_ready[ch] = 1'b0; rcnt[ch] = 0; wcnt[ch] = 0;
    end
    f_mrr[0] = 1'b1; f_mrd[0] = 8'h00; f_mwr[0] = 1'b0;
    wr_log_addr = 8'h00; wr_log_data = 8'h00;

    @(posedge clk); @(posedge clk); #1;
    sum = 0;
    for (int ch = 0; ch < NCH; ch++) sum += int'(mem_read_valid[ch]) + int'(mem_write_valid[ch]) +
                                        int'(mem_read_address[ch]) + int'(mem_write_address[ch]) +
                                        int'(mem_write_data[ch]);
    for (int c = 0; c < NC; c++) sum += int'(consumer_read_ready[c]) + int'(consumer_write_ready[c]) +
                                        int'(consumer_read_data[c]);
    check("reset_outputs_zero", 32'(sum), 32'd0);
    reset = 1'b0;

    // Table-driven single transactions.
    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Oversubscription: all eight consumers read at once.
    lat_g = 0;
    for (int c = 0; c < NC; c++) begin
      served[c] = 0; served_at[c] = 0;
      consumer_read_address[c] = ov_addr[c];
      consumer_read_valid[c] = 1'b1;
    end
    cyc_g = 0;
    tick();
    bad = 0;
    for (int ch = 0; ch < NCH; ch++) begin
      if (mem_read_valid[ch] !== 1'b1 || mem_read_address[ch] !== ov_addr[ch]) bad++;
    end
    check("oversub first wave claims", 32'(bad), 32'd0);
    cyc = 0;
    sum = 0;
    while (sum < NC && cyc < 60) begin
      tick();
      cyc++;
      sum = 0;
      for (int c = 0; c < NC; c++) sum += (served[c] != 0) ? 1 : 0;
    end
    for (int c = 0; c < NC; c++) begin
      check($sformatf("oversub served_once c%0d", c), 32'(served[c]), 32'd1);
      check($sformatf("oversub data c%0d", c), 32'(got[c]), 32'(ov_data[c]));
      check($sformatf("oversub served_cycle c%0d", c), 32'(served_at[c]), (c < 4) ? 32'd2 : 32'd5);
    end
    tick(); tick();

    // Fairness on the single-channel instance.
    f_en = 1'b1;
    cyc = 0;
    while (f_ng < 4 && cyc < 40) begin
      tick();
      cyc++;
    end
    f_en = 1'b0;
    check("fair grant count", 32'(f_ng >= 4), 32'd1);
    for (int g = 0; g < 4; g++) begin
      check($sformatf("fair grant%0d", g), 32'(f_grant[g]), 32'(fair_exp[g]));
    end
    tick(); tick(); tick();

    // Reset while channel 0 waits on slow memory.
    lat_g = 20;
    consumer_read_address[1] = 8'h77;
    consumer_read_valid[1] = 1'b1;
    tick(); tick(); tick();
    check("pre-reset read pending", 32'(mem_read_valid[0]), 32'd1);
    reset = 1'b1;
    #1;
    check("reset mid mem_read_valid", 32'(mem_read_valid[0]), 32'd0);
    check("reset mid mem_read_address", 32'(mem_read_address[0]), 32'd0);
    consumer_read_valid[1] = 1'b0;
    for (int ch = 0; ch < NCH; ch++) begin
      mem_read_ready[ch] = 1'b0; rcnt[ch] = 0;
    end
    @(posedge clk); #1;
    reset = 1'b0;
    fresh = '{1'b0, 1, 8'h77, 8'h00, 0, 8'hC1};
    run_vec(fresh, "post_reset");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
